bfp_systolic_skew_feeder: RTL and testbench

- Consumes the block-floating-point vectors from the FP-to-BFP converter: 32 aligned mantissas plus one shared exponent.
- Buffers them in a small vector FIFO.
- Issues them to the 32-row systolic array as a diagonal wavefront: row k receives a vector exactly k cycles after row 0.
- Decouples converter throughput from array stalls via valid/ready on the input and a global enable on the output.

---
 rtl/bfp_systolic_skew_feeder.sv | 108 ++++++++++
 tb/tb_bfp_systolic_skew_feeder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_systolic_skew_feeder.sv
// BFP vector feeder: buffers converter output in a small vector FIFO and launches
// each vector into the systolic array as a diagonal wavefront (row k lags row 0 by k cycles).
module bfp_systolic_skew_feeder #(
   parameter int SYST_ARRAY_WIDTH         = 32,
   parameter int QUNATIZED_MANTISSA_WIDTH = 7,
   parameter int EXPONENT_WIDTH           = 8,
   parameter int FIFO_DEPTH               = 4
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic [QUNATIZED_MANTISSA_WIDTH*SYST_ARRAY_WIDTH-1:0] bfp_mantissa_i,
   input  logic [EXPONENT_WIDTH-1:0]                            bfp_exponent_i,
   input  logic                                                 bfp_valid_i,
   output logic                                                 bfp_ready_o,
   input  logic                                                 array_en_i,
   output logic [QUNATIZED_MANTISSA_WIDTH*SYST_ARRAY_WIDTH-1:0] skew_mantissa_o,
   output logic [SYST_ARRAY_WIDTH-1:0]                          skew_valid_o,
   output logic [EXPONENT_WIDTH-1:0]                            skew_exponent_o,
   output logic                                                 skew_exponent_valid_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]                      fifo_count_o,
   output logic                                                 busy_o
);

   localparam int MW    = QUNATIZED_MANTISSA_WIDTH;
   localparam int VW    = MW * SYST_ARRAY_WIDTH;
   localparam int EW    = EXPONENT_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [VW-1:0]    mant_mem [FIFO_DEPTH];
   logic [EW-1:0]    exp_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [VW-1:0]    head_mant;
   logic [EW-1:0]    head_exp;
   logic [EW-1:0]    exp_q;

   assign full        = (count == CNT_W'(FIFO_DEPTH));
   assign empty       = (count == '0);
   // Ready looks only at the registered count; a same-cycle pop does not free a slot.
   assign bfp_ready_o = !rst && !full;
   assign push        = bfp_valid_i && bfp_ready_o;
   assign pop         = array_en_i && !empty;
   assign head_mant   = mant_mem[rd_ptr];
   assign head_exp    = exp_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mant_mem[wr_ptr] <= bfp_mantissa_i;
         exp_mem[wr_ptr]  <= bfp_exponent_i;
      end
   end

   // Exponent rides with row 0 and keeps its last value across bubbles.
   always_ff @(posedge clk) begin
      if (rst)      exp_q <= '0;
      else if (pop) exp_q <= head_exp;
   end

   for (genvar k = 0; k < SYST_ARRAY_WIDTH; k++) begin : g_lane
      logic [MW-1:0] mant_q [k+1];
      logic [k:0]    vld_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= k; s++) mant_q[s] <= '0;
            vld_q <= '0;
         end else if (array_en_i) begin
            mant_q[0] <= pop ? head_mant[k*MW +: MW] : '0;
            vld_q[0]  <= pop;
            for (int s = 1; s <= k; s++) begin
               mant_q[s] <= mant_q[s-1];
               vld_q[s]  <= vld_q[s-1];
            end
         end
      end

      assign skew_valid_o[k]              = vld_q[k];
      assign skew_mantissa_o[k*MW +: MW]  = vld_q[k] ? mant_q[k] : '0;
   end

   assign skew_exponent_o       = exp_q;
   assign skew_exponent_valid_o = skew_valid_o[0];
   assign fifo_count_o          = count;
   assign busy_o                = !empty || (|skew_valid_o);

endmodule

// File: tb/tb_bfp_systolic_skew_feeder.sv
// Self-checking bench for bfp_systolic_skew_feeder: table-driven FIFO-full sequence,
// hand-written wavefront/stall/reset sequences and random traffic against an issue-history model.
module tb_bfp_systolic_skew_feeder;

   localparam int N     = 32;
   localparam int MW    = 7;
   localparam int VW    = N * MW;
   localparam int EW    = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [VW-1:0] bfp_mantissa_i = '0;
   logic [EW-1:0] bfp_exponent_i = '0;
   logic          bfp_valid_i = 1'b0;
   logic          bfp_ready_o;
   logic          array_en_i = 1'b0;
   logic [VW-1:0] skew_mantissa_o;
   logic [N-1:0]  skew_valid_o;
   logic [EW-1:0] skew_exponent_o;
   logic          skew_exponent_valid_o;
   logic [2:0]    fifo_count_o;
   logic          busy_o;

   bfp_systolic_skew_feeder #(
      .SYST_ARRAY_WIDTH(N), .QUNATIZED_MANTISSA_WIDTH(MW),
      .EXPONENT_WIDTH(EW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .bfp_mantissa_i(bfp_mantissa_i), .bfp_exponent_i(bfp_exponent_i),
      .bfp_valid_i(bfp_valid_i), .bfp_ready_o(bfp_ready_o),
      .array_en_i(array_en_i),
      .skew_mantissa_o(skew_mantissa_o), .skew_valid_o(skew_valid_o),
      .skew_exponent_o(skew_exponent_o), .skew_exponent_valid_o(skew_exponent_valid_o),
      .fifo_count_o(fifo_count_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [VW-1:0] mant; logic [EW-1:0] exp; } vec_t;
   typedef struct { logic v; logic [VW-1:0] mant; } slot_t;
   typedef struct { logic valid; logic en; int id; int exp_count; logic exp_ready; } tvec_t;

   // Reference: queue of buffered vectors plus history of what was issued on each advance;
   // row k shows whatever was issued k advances ago.
   vec_t          mq[$];
   slot_t         hist [N];
   logic [EW-1:0] last_exp;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] fill(input int val);
      logic [VW-1:0] m;
      for (int k = 0; k < N; k++) m[k*MW +: MW] = MW'(val);
      return m;
   endfunction

   function automatic logic [MW-1:0] lane(input logic [VW-1:0] m, input int k);
      return m[k*MW +: MW];
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int k = 0; k < N; k++) begin
         hist[k].v    = 1'b0;
         hist[k].mant = '0;
      end
      last_exp = '0;
   endtask

   task automatic model_edge();
      bit push_ok;
      if (rst) begin
         model_reset();
         return;
      end
      push_ok = bfp_valid_i && (mq.size() < DEPTH);
      if (array_en_i) begin
         for (int k = N-1; k > 0; k--) hist[k] = hist[k-1];
         if (mq.size() > 0) begin
            hist[0].v    = 1'b1;
            hist[0].mant = mq[0].mant;
            last_exp     = mq[0].exp;
            void'(mq.pop_front());
         end else begin
            hist[0].v    = 1'b0;
            hist[0].mant = '0;
         end
      end
      if (push_ok) mq.push_back('{mant: bfp_mantissa_i, exp: bfp_exponent_i});
   endtask

   task automatic compare_model();
      logic [N-1:0]  ev;
      logic [VW-1:0] em;
      for (int k = 0; k < N; k++) begin
         ev[k] = hist[k].v;
         em[k*MW +: MW] = hist[k].v ? lane(hist[k].mant, k) : '0;
      end
      chk("valid", skew_valid_o, ev);
      chk("mantissa", skew_mantissa_o, em);
      chk("exponent", skew_exponent_o, last_exp);
      chk("exp_valid", skew_exponent_valid_o, ev[0]);
      chk("count", fifo_count_o, mq.size());
      chk("ready", bfp_ready_o, !rst && (mq.size() < DEPTH));
      chk("busy", busy_o, (mq.size() > 0) || (|ev));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic drive(input logic v, input logic en, input logic [VW-1:0] m, input logic [EW-1:0] e);
      bfp_valid_i    = v;
      array_en_i     = en;
      bfp_mantissa_i = m;
      bfp_exponent_i = e;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b1, '0, '0);
      repeat (n) step();
   endtask

   tvec_t tbl[10];

   initial begin
      int   sent;
      int   cyc;
      int   stale;
      logic acc;
      logic [VW-1:0] rm;
      logic [EW-1:0] re;

      model_reset();

      // Reset: ready low while rst, everything cleared.
      rst = 1'b1;
      step();
      step();
      chk("rst_ready_low", bfp_ready_o, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b1, '0, '0);
      step();
      chk("post_rst_ready", bfp_ready_o, 1'b1);
      chk("post_rst_count", fifo_count_o, 0);

      // Single vector: lane k = k+1, exponent 0x85.
      for (int k = 0; k < N; k++) rm[k*MW +: MW] = MW'(k + 1);
      drive(1'b1, 1'b1, rm, 8'h85);
      step();
      drive(1'b0, 1'b1, '0, '0);
      step();
      chk("single_row0_valid", skew_valid_o, 32'h0000_0001);
      chk("single_row0_mant", skew_mantissa_o[6:0], 7'd1);
      chk("single_row0_exp", skew_exponent_o, 8'h85);
      repeat (31) step();
      chk("single_row31_valid", skew_valid_o, 32'h8000_0000);
      chk("single_row31_mant", skew_mantissa_o[VW-1 -: MW], 7'd32);
      chk("single_busy_hi", busy_o, 1'b1);
      step();
      chk("single_busy_fall", busy_o, 1'b0);
      chk("single_exp_hold", skew_exponent_o, 8'h85);
      idle(4);

      // Back-to-back: ids 0..5 at full rate.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, fill(i), EW'(8'h10 + i));
         step();
         chk("b2b_ready", bfp_ready_o, 1'b1);
      end
      drive(1'b0, 1'b1, '0, '0);
      repeat (27) step();
      for (int i = 0; i < 6; i++) begin
         chk("b2b_row31_valid", skew_valid_o[31], 1'b1);
         chk("b2b_row31_id", skew_mantissa_o[VW-1 -: MW], MW'(i));
         step();
      end
      idle(40);

      // Full FIFO, table-driven: stall, push 5, then release.
      tbl[0] = '{1'b1, 1'b0, 1, 1, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 2, 2, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 3, 3, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 4, 4, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 5, 4, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 5, 3, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 5, 3, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 0, 2, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 0, 1, 1'b1};
      tbl[9] = '{1'b0, 1'b1, 0, 0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].valid, tbl[i].en, fill(tbl[i].id), EW'(tbl[i].id));
         step();
         chk($sformatf("full_tbl%0d_count", i), fifo_count_o, tbl[i].exp_count);
         chk($sformatf("full_tbl%0d_ready", i), bfp_ready_o, tbl[i].exp_ready);
      end
      idle(40);

      // Stall 3 cycles while the vector sits at row 10.
      drive(1'b1, 1'b1, fill(9), 8'h42);
      step();
      drive(1'b0, 1'b1, '0, '0);
      repeat (11) step();
      chk("stall_row10", skew_valid_o, 32'h0000_0400);
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_frozen_valid", skew_valid_o, 32'h0000_0400);
         chk("stall_frozen_mant", skew_mantissa_o[10*MW +: MW], 7'd9);
      end
      drive(1'b0, 1'b1, '0, '0);
      repeat (20) step();
      chk("stall_row31_early", skew_valid_o[31], 1'b0);
      step();
      chk("stall_row31_arrive", skew_valid_o[31], 1'b1);
      chk("stall_row31_mant", skew_mantissa_o[VW-1 -: MW], 7'd9);
      idle(4);

      // Reset mid-operation: 2 in flight, 3 buffered.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, fill(20 + i), EW'(20 + i));
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, fill(30 + i), EW'(30 + i));
         step();
      end
      chk("pre_rst_count", fifo_count_o, 3);
      rst = 1'b1;
      drive(1'b1, 1'b1, fill(40), 8'h40);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b1, '0, '0);
      #1;
      chk("rst_mid_valid", skew_valid_o, '0);
      chk("rst_mid_mant", skew_mantissa_o, '0);
      chk("rst_mid_exp", skew_exponent_o, '0);
      chk("rst_mid_count", fifo_count_o, 0);
      chk("rst_mid_ready", bfp_ready_o, 1'b1);
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (skew_valid_o != '0) stale++;
      end
      chk("rst_no_stale", stale, 0);

      // Random traffic with wrap-around; upstream holds data until accepted.
      sent = 0;
      cyc  = 0;
      for (int k = 0; k < N; k++) rm[k*MW +: MW] = MW'($urandom_range(0, 127));
      re = EW'($urandom);
      while (sent < 20 && cyc < 500) begin
         drive((($urandom % 2) == 1), (($urandom % 2) == 1), rm, re);
         acc = bfp_valid_i && (mq.size() < DEPTH);
         step();
         cyc++;
         if (acc) begin
            sent++;
            for (int k = 0; k < N; k++) rm[k*MW +: MW] = MW'($urandom_range(0, 127));
            re = EW'($urandom);
         end
      end
      chk("rand_all_sent", sent, 20);
      idle(40);
      chk("rand_drained", busy_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
